// File: rtl/vga_scanout_if.sv
// Framebuffer read port and front/back swap handshake between scanout, RAM and drawing engine.
interface vga_scanout_if #(
  parameter int unsigned ADDR_W = 17
) ();

  logic              swap_req;
  logic              swap_ack;
  logic              front_buf;
  logic              fb_rd_en;
  logic [ADDR_W:0]   fb_addr;
  logic [7:0]        fb_rd_data;

  // Scanout side.
  modport master (
    input  swap_req,
    input  fb_rd_data,
    output swap_ack,
    output front_buf,
    output fb_rd_en,
    output fb_addr
  );

  // RAM / drawing-engine side.
  modport slave (
    output swap_req,
    output fb_rd_data,
    input  swap_ack,
    input  front_buf,
    input  fb_rd_en,
    input  fb_addr
  );

endinterface

// File: rtl/vga_scanout.sv
// VGA scanout: two pix_clk-tick pipeline from iterator to pins, reading an RGB332 double buffer.
// Optional VGA_TESTPAT_EN adds test_mode, which replaces RAM colour with 8 vertical colour bars.
module vga_scanout #(
  parameter int unsigned H_OFFSET    = 160,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned FB_W        = 320,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_clk,
  input  logic [9:0]    pix_x,
  input  logic [8:0]    pix_y,
  input  logic          h_sync_in,
  input  logic          v_sync_in,
  input  logic          draw_active,
  input  logic          screen_end,
`ifdef VGA_TESTPAT_EN
  input  logic          test_mode,
`endif
  vga_scanout_if.master bus,
  output logic [2:0]    vga_r,
  output logic [2:0]    vga_g,
  output logic [1:0]    vga_b,
  output logic          vga_hs,
  output logic          vga_vs
);

  localparam logic [9:0]        XStart = 10'(H_OFFSET);
  localparam logic [9:0]        XEnd   = 10'(H_OFFSET + 640);
  localparam logic [ADDR_W-1:0] FbW    = ADDR_W'(FB_W);

  typedef enum logic [1:0] {StIdle, StPend, StAck} swap_state_e;

  swap_state_e state_q;
  logic        front_buf_q;
  logic        swap_ack_q;

  logic [ADDR_W:0]   fb_addr_q, fb_addr_d;
  logic              fb_rd_en_q, fb_rd_en_d;
  logic              rd_pend_q, rd_pend_d;
  logic [7:0]        data_q, data_d;
  logic              vis1_q, vis1_d;
  logic              hs1_q, hs1_d;
  logic              vs1_q, vs1_d;
  logic [7:0]        rgb_q, rgb_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;

  logic [9:0]        x_off;
  logic              vis;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] idx;
  logic              rd_allow;
  logic [7:0]        data_sel;
  logic [7:0]        pix_rgb;

`ifdef VGA_TESTPAT_EN
  logic       tp_q, tp_d;
  logic [2:0] bar_q, bar_d;
  assign rd_allow = ~test_mode;
`else
  assign rd_allow = 1'b1;
`endif

  // Stage-1 address arithmetic; x_off wraps for pix_x < H_OFFSET but vis masks those columns.
  always_comb begin
    x_off = pix_x - XStart;
    vis   = draw_active && (pix_x >= XStart) && (pix_x < XEnd);
    col   = ADDR_W'(x_off >> SCALE_SHIFT);
    row   = ADDR_W'(pix_y >> SCALE_SHIFT);
    idx   = row * FbW + col;
  end

  // Data valid the clk after the RAM sees fb_rd_en; bypass lets a tick on that clk use it.
  always_comb begin
    data_sel = rd_pend_q ? bus.fb_rd_data : data_q;
    pix_rgb  = data_sel;
`ifdef VGA_TESTPAT_EN
    if (tp_q) begin
      pix_rgb = {bar_q[2] ? 3'd7 : 3'd0, bar_q[1] ? 3'd7 : 3'd0, bar_q[0] ? 2'd3 : 2'd0};
    end
`endif
  end

  always_comb begin
    fb_addr_d  = fb_addr_q;
    vis1_d     = vis1_q;
    hs1_d      = hs1_q;
    vs1_d      = vs1_q;
    rgb_d      = rgb_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    fb_rd_en_d = pix_clk && vis && rd_allow;
    rd_pend_d  = fb_rd_en_q;
    data_d     = data_sel;
`ifdef VGA_TESTPAT_EN
    tp_d       = tp_q;
    bar_d      = bar_q;
`endif
    if (pix_clk) begin
      // front_buf_q is the pre-toggle value on a swapping tick, so the frame stays in one buffer.
      fb_addr_d = {front_buf_q, idx};
      vis1_d    = vis;
      hs1_d     = h_sync_in;
      vs1_d     = v_sync_in;
      rgb_d     = vis1_q ? pix_rgb : 8'h00;
      hs_d      = hs1_q;
      vs_d      = vs1_q;
`ifdef VGA_TESTPAT_EN
      tp_d      = test_mode;
      bar_d     = 3'(x_off / 10'd80);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_addr_q  <= '0;
      fb_rd_en_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      data_q     <= 8'h00;
      vis1_q     <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      rgb_q      <= 8'h00;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
`ifdef VGA_TESTPAT_EN
      tp_q       <= 1'b0;
      bar_q      <= 3'd0;
`endif
    end else begin
      fb_addr_q  <= fb_addr_d;
      fb_rd_en_q <= fb_rd_en_d;
      rd_pend_q  <= rd_pend_d;
      data_q     <= data_d;
      vis1_q     <= vis1_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      rgb_q      <= rgb_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
`ifdef VGA_TESTPAT_EN
      tp_q       <= tp_d;
      bar_q      <= bar_d;
`endif
    end
  end

  // Swap handshake runs every clk; the buffer flips only on a screen_end tick while pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      front_buf_q <= 1'b0;
      swap_ack_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          swap_ack_q <= 1'b0;
          if (bus.swap_req) state_q <= StPend;
        end
        StPend: begin
          if (!bus.swap_req) begin
            state_q <= StIdle;
          end else if (pix_clk && screen_end) begin
            front_buf_q <= ~front_buf_q;
            swap_ack_q  <= 1'b1;
            state_q     <= StAck;
          end
        end
        StAck: begin
          if (!bus.swap_req) begin
            swap_ack_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: begin
          swap_ack_q <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign bus.fb_addr   = fb_addr_q;
  assign bus.fb_rd_en  = fb_rd_en_q;
  assign bus.front_buf = front_buf_q;
  assign bus.swap_ack  = swap_ack_q;

  assign vga_r  = rgb_q[7:5];
  assign vga_g  = rgb_q[4:2];
  assign vga_b  = rgb_q[1:0];
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: expected pin values queued per tick, popped two ticks later.
module tb_vga_scanout;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    logic       hs;
    logic       vs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_clk;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic       h_sync_in;
  logic       v_sync_in;
  logic       draw_active;
  logic       screen_end;
`ifdef VGA_TESTPAT_EN
  logic       test_mode;
`endif
  logic [2:0] vga_r;
  logic [2:0] vga_g;
  logic [1:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;

  int   vectors = 0;
  int   miscompares = 0;
  bit   exp_fb;
  bit   req_lvl;
  exp_t q[$];
  exp_t idle_exp;

  vga_scanout_if #(.ADDR_W(17)) bus ();

  vga_scanout #(
    .H_OFFSET   (160),
    .SCALE_SHIFT(1),
    .FB_W       (320),
    .ADDR_W     (17)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_clk    (pix_clk),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .draw_active(draw_active),
    .screen_end (screen_end),
`ifdef VGA_TESTPAT_EN
    .test_mode  (test_mode),
`endif
    .bus        (bus),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_val(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'hE3;
  endfunction

  // Synchronous RAM model: data valid the clk after the read enable.
  always @(posedge clk) begin
    if (bus.fb_rd_en) bus.fb_rd_data <= ram_val(bus.fb_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_r"}, 32'(vga_r), 0);
    chk({tag, "_g"}, 32'(vga_g), 0);
    chk({tag, "_b"}, 32'(vga_b), 0);
    chk({tag, "_hs"}, 32'(vga_hs), 1);
    chk({tag, "_vs"}, 32'(vga_vs), 1);
    chk({tag, "_rd_en"}, 32'(bus.fb_rd_en), 0);
    chk({tag, "_addr"}, 32'(bus.fb_addr), 0);
    chk({tag, "_front_buf"}, 32'(bus.front_buf), 0);
    chk({tag, "_swap_ack"}, 32'(bus.swap_ack), 0);
  endtask

  task automatic set_req(input bit v);
    @(negedge clk);
    req_lvl      = v;
    bus.swap_req = v;
  endtask

  task automatic chk_swap(input string tag, input bit fb, input bit ack);
    chk({tag, "_front_buf"}, 32'(bus.front_buf), 32'(fb));
    chk({tag, "_swap_ack"}, 32'(bus.swap_ack), 32'(ack));
  endtask

  // One pixel tick followed by `gap` idle clks.
  task automatic tick(input int x, input int y, input bit da, input bit se = 1'b0,
                      input bit hs = 1'b1, input bit vs = 1'b1, input int gap = 3);
    exp_t        e;
    bit          vis;
    bit          rd_exp;
    int          idx;
    logic [17:0] a;
    logic [7:0]  d;
    logic [2:0]  bar;
    @(negedge clk);
    pix_x        = 10'(x);
    pix_y        = 9'(y);
    draw_active  = da;
    screen_end   = se;
    h_sync_in    = hs;
    v_sync_in    = vs;
    bus.swap_req = req_lvl;
    pix_clk      = 1'b1;
    vis    = da && (x >= 160) && (x < 800);
    idx    = (x >= 160) ? ((y / 2) * 320 + (x - 160) / 2) : 0;
    a      = {exp_fb, 17'(idx)};
    d      = ram_val(a);
    rd_exp = vis;
    e.r    = vis ? d[7:5] : 3'd0;
    e.g    = vis ? d[4:2] : 3'd0;
    e.b    = vis ? d[1:0] : 2'd0;
    e.hs   = hs;
    e.vs   = vs;
`ifdef VGA_TESTPAT_EN
    if (test_mode) begin
      rd_exp = 1'b0;
      bar    = 3'((x >= 160) ? (x - 160) / 80 : 0);
      e.r    = (vis && bar[2]) ? 3'd7 : 3'd0;
      e.g    = (vis && bar[1]) ? 3'd7 : 3'd0;
      e.b    = (vis && bar[0]) ? 2'd3 : 2'd0;
    end
`endif
    q.push_back(e);
    @(negedge clk);
    pix_clk    = 1'b0;
    screen_end = 1'b0;
    chk("rd_en", 32'(bus.fb_rd_en), 32'(rd_exp));
    if (x >= 160) chk("addr", 32'(bus.fb_addr), 32'(a));
    e = q.pop_front();
    chk("vga_rgb", 32'({vga_r, vga_g, vga_b}), 32'({e.r, e.g, e.b}));
    chk("vga_sync", 32'({vga_hs, vga_vs}), 32'({e.hs, e.vs}));
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (i == 0) chk("rd_pulse", 32'(bus.fb_rd_en), 0);
      chk("hold_rgb", 32'({vga_r, vga_g, vga_b}), 32'({e.r, e.g, e.b}));
      chk("hold_sync", 32'({vga_hs, vga_vs}), 32'({e.hs, e.vs}));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_exp     = '{r: 3'd0, g: 3'd0, b: 2'd0, hs: 1'b1, vs: 1'b1};
    rst          = 1'b1;
    pix_clk      = 1'b0;
    pix_x        = '0;
    pix_y        = '0;
    h_sync_in    = 1'b1;
    v_sync_in    = 1'b1;
    draw_active  = 1'b0;
    screen_end   = 1'b0;
    req_lvl      = 1'b0;
    bus.swap_req = 1'b0;
`ifdef VGA_TESTPAT_EN
    test_mode    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset("init");
    q.push_back(idle_exp);
    exp_fb = 1'b0;

    // Address generation, blanking edges and RAM colour.
    tick(160, 0, 1'b1);
    tick(161, 0, 1'b1);
    tick(162, 0, 1'b1);
    tick(801, 3, 1'b1);
    tick(800, 3, 1'b1);
    tick(799, 479, 1'b1);
    tick(400, 100, 1'b0);
    tick(300, 50, 1'b1);

    // Sync latency and a long pix_clk gap.
    tick(300, 50, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(302, 50, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(304, 50, 1'b1, 1'b0, 1'b1, 1'b0, 7);
    tick(306, 50, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(308, 51, 1'b1);
    tick(310, 51, 1'b1);

    // Swap: no toggle before screen_end, then ack held until request drops.
    set_req(1'b1);
    tick(320, 60, 1'b1);
    tick(322, 60, 1'b1);
    chk_swap("pend", 1'b0, 1'b0);
    tick(324, 60, 1'b1, 1'b1);
    exp_fb = 1'b1;
    chk_swap("swapped", 1'b1, 1'b1);
    tick(326, 60, 1'b1);
    repeat (5) @(negedge clk);
    chk_swap("ack_hold", 1'b1, 1'b1);
    set_req(1'b0);
    @(negedge clk);
    chk_swap("ack_drop", 1'b1, 1'b0);

    // Cancel while pending.
    set_req(1'b1);
    repeat (2) @(negedge clk);
    set_req(1'b0);
    tick(330, 60, 1'b1, 1'b1);
    chk_swap("cancel", 1'b1, 1'b0);

    // Request rises on the same tick as screen_end: swap waits for the next frame end.
    req_lvl = 1'b1;
    tick(332, 60, 1'b1, 1'b1);
    chk_swap("simul", 1'b1, 1'b0);
    tick(334, 60, 1'b1, 1'b1);
    exp_fb = 1'b0;
    chk_swap("simul_next", 1'b0, 1'b1);
    set_req(1'b0);
    tick(336, 60, 1'b1);
    chk_swap("simul_done", 1'b0, 1'b0);

    // Reach front_buf=1 with ack high and h_sync low, then reset mid-frame.
    set_req(1'b1);
    tick(338, 60, 1'b1);
    tick(338, 60, 1'b1, 1'b1);
    exp_fb = 1'b1;
    chk_swap("pre_rst", 1'b1, 1'b1);
    tick(340, 60, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(342, 60, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst          = 1'b1;
    pix_clk      = 1'b1;
    pix_x        = 10'd344;
    draw_active  = 1'b1;
    h_sync_in    = 1'b0;
    req_lvl      = 1'b0;
    bus.swap_req = 1'b0;
    repeat (3) @(negedge clk);
    rst       = 1'b0;
    pix_clk   = 1'b0;
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    chk_reset("midrst");
    q.delete();
    q.push_back(idle_exp);
    exp_fb = 1'b0;

    tick(160, 0, 1'b1);
    tick(480, 240, 1'b1);
    tick(100, 0, 1'b1);
    tick(0, 0, 1'b0);

`ifdef VGA_TESTPAT_EN
    test_mode = 1'b1;
    tick(245, 0, 1'b1);
    tick(165 + 80 * 6, 0, 1'b1);
    tick(799, 0, 1'b1);
    tick(800, 0, 1'b1);
    tick(170, 0, 1'b1);
    test_mode = 1'b0;
    tick(400, 10, 1'b1);
`endif

    tick(200, 20, 1'b1);
    tick(202, 20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Consumes the pixel iterator outputs: pix_x, pix_y, h_sync, v_sync, draw_active and screen_end.
- Fetches each visible pixel from a double-buffered 8-bit framebuffer RAM, with 2x upscaling by default.
- Drives the VGA pins with RGB332 colour and syncs, delay-matched to the RAM latency.
- Owns the front/back buffer swap handshake with the drawing engine. Swaps happen only at frame end.

Parameters:
H_OFFSET, 160, pix_x value of the first visible column
SCALE_SHIFT, 1, log2 of the upscale factor (0 = 640x480 buffer, 1 = 320x240 buffer)
FB_W, 320, framebuffer width in pixels (640 >> SCALE_SHIFT)
ADDR_W, 17, per-buffer address width; must cover FB_W*FB_H

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
pix_clk  in  1  pixel clock enable (one-clk pulse per pixel)
pix_x  in  10  horizontal position from the iterator
pix_y  in  9  vertical position from the iterator
h_sync_in  in  1  iterator h_sync, active low
v_sync_in  in  1  iterator v_sync, active low
draw_active  in  1  iterator visible-area flag
screen_end  in  1  iterator last-position-of-frame flag
swap_req  in  1  drawing engine requests a buffer swap (4-phase)
swap_ack  out  1  swap done; held until swap_req drops
front_buf  out  1  index of the buffer currently scanned out
fb_rd_en  out  1  RAM read enable
fb_addr  out  ADDR_W+1  RAM address = {front_buf, pixel index}
fb_rd_data  in  8  RAM data, valid the clk after fb_rd_en (sync RAM)
vga_r  out  3  red
vga_g  out  3  green
vga_b  out  2  blue
vga_hs  out  1  h sync to pin, active low
vga_vs  out  1  v sync to pin, active low

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - Every state update is gated by pix_clk, except the RAM data capture and the swap FSM.
- Reset values:
  - vga_r, vga_g, vga_b = 0; vga_hs = vga_vs = 1.
  - fb_rd_en = 0, fb_addr = 0.
  - swap_ack = 0, front_buf = 0, FSM = IDLE.
  - Pipeline valid bits cleared.
  - Reset mid-frame takes effect the next clk and overrides pix_clk.
- Stage 1 (pix_clk tick):
  - vis = draw_active && pix_x >= H_OFFSET && pix_x < H_OFFSET+640. Column pix_x = H_OFFSET+640 is blanked even if draw_active is high.
  - col = (pix_x - H_OFFSET) >> SCALE_SHIFT; row = pix_y >> SCALE_SHIFT.
  - idx = row*FB_W + col, computed in ADDR_W bits with no wrap (max 76799 at default).
  - Register fb_addr = {front_buf, idx} and fb_rd_en = vis. fb_rd_en is a one-clk pulse; it is 0 on non-tick clks.
  - Register vis, h_sync_in and v_sync_in into stage 1.
- Data capture: on the clk after fb_rd_en, latch fb_rd_data into a holding register, independent of pix_clk.
- Stage 2 (next pix_clk tick):
  - vga_r/g/b = vis1 ? {data[7:5], data[4:2], data[1:0]} : 0.
  - vga_hs/vga_vs = stage-1 copies.
  - Total latency from iterator inputs to pins: 2 pix_clk ticks, identical for colour and syncs.
  - Outputs hold between ticks.
- Swap FSM (evaluated every clk):
  - IDLE: swap_ack = 0. swap_req = 1 moves to PEND.
  - PEND: if swap_req drops, return to IDLE with no swap (cancel). Else on pix_clk && screen_end: toggle front_buf, set swap_ack = 1, move to ACK.
  - ACK: swap_ack = 1. swap_req = 0 clears swap_ack and moves to IDLE.
  - Simultaneous swap_req rise and screen_end tick in IDLE: enter PEND only. The swap occurs at the next frame end.
- Address stability: front_buf changes only at screen_end, so a frame is never split across buffers. Stage-1 fb_addr uses the front_buf value before the toggle.

Optional Feature:
- Macro: VGA_TESTPAT_EN.
- When defined:
  - Adds input test_mode (1 bit).
  - While test_mode = 1, stage 2 outputs 8 vertical colour bars, each 80 visible columns wide. Bar k (0..7) = {r=k[2]?7:0, g=k[1]?7:0, b=k[0]?3:0}.
  - fb_rd_en is forced to 0; syncs and blanking are unchanged.
- When undefined: the port is absent and colour always comes from RAM.

Test Plan:
- rst held 3 clks mid-frame -> vga_hs = vga_vs = 1, rgb = 0, fb_rd_en = 0, front_buf = 0, swap_ack = 0 on the first clk after rst.
- Tick with pix_x=160, pix_y=0, draw_active=1 -> fb_addr=0 with fb_rd_en pulse. RAM returns 0xE3 -> after 2 ticks rgb = 7/0/3.
- Inputs pix_x=801 (col 320), pix_y=3 -> fb_addr = 1*320+320 = 640. Then pix_x=800, draw_active=1 -> fb_rd_en=0, rgb=0 two ticks later.
- h_sync_in driven low at tick N -> vga_hs low at tick N+2. A pix_clk gap of 4 clks between ticks -> outputs unchanged across the gap.
- swap_req=1 in mid-frame -> no toggle until the screen_end tick. Then front_buf=1 and swap_ack=1 until swap_req=0, then ack=0 next clk. swap_req dropped while PEND -> front_buf unchanged.
- VGA_TESTPAT_EN, test_mode=1, pix_x=160+85 -> rgb = 0/0/3 (bar 1), fb_rd_en never asserted.
